// File: rtl/uart_reg_bridge.sv
// UART command responder: decodes 1-byte read / 2-byte write frames from the
// RX FIFO into single-cycle register strobes and answers each completed frame
// with exactly one byte pushed into the TX FIFO.
module uart_reg_bridge #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rd_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic [7:0]        wr_data,
    output logic              wr_uart,
    input  logic              tx_full,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        REG_WRITE,
        REG_READ,
        WAIT_RD,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] resp;
    logic              timeout;

    // State register; reset abandons any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, FIFO handshakes and timeout detection
    always_comb begin
        state_next = state;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so no pop is requested while held in reset
                rd_uart = reset & ~rx_empty;
                if (reset && !rx_empty) begin
                    state_next = rd_data[7] ? GET_DATA : REG_READ;
                end
            end
            GET_DATA: begin
                rd_uart = ~rx_empty;
                // A byte present in the expiry cycle still wins over the timeout
                if (!rx_empty) begin
                    state_next = REG_WRITE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            REG_WRITE: state_next = SEND;
            REG_READ:  state_next = WAIT_RD;
            WAIT_RD: begin
                // Read data arriving in the expiry cycle wins over the timeout
                if (reg_rvalid) begin
                    state_next = SEND;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame capture, response byte, timeout counter and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            resp      <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout;

            if (state == IDLE && rd_uart) begin
                reg_addr <= rd_data[ADDR_W-1:0];
            end
            if (state == GET_DATA && rd_uart) begin
                reg_wdata <= rd_data;
            end

            if (state == REG_WRITE) begin
                resp <= ACK_BYTE;
            end else if (state == WAIT_RD) begin
                if (reg_rvalid) begin
                    resp <= reg_rdata;
                end else if (timeout) begin
                    resp <= NAK_BYTE;
                end
            end

            // Counts only while waiting; cleared in every other state so each
            // wait starts from zero. Saturates instead of wrapping.
            if ((state == GET_DATA && rx_empty) || state == WAIT_RD) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign wr_data = resp;
    assign reg_wr  = (state == REG_WRITE);
    assign reg_rd  = (state == REG_READ);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with an RX FIFO model, a TX capture queue
// and a register responder that answers reg_rd after a programmable delay.
module tb_uart_reg_bridge;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rd_uart;
    logic [7:0] wr_data;
    logic       wr_uart;
    logic       tx_full = 1'b0;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic       frame_err;

    uart_reg_bridge #(
        .ADDR_W(7),
        .DATA_W(8),
        .TIMEOUT_CYC(TO),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_data(rd_data),
        .rx_empty(rx_empty),
        .rd_uart(rd_uart),
        .wr_data(wr_data),
        .wr_uart(wr_uart),
        .tx_full(tx_full),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr(reg_wr),
        .reg_rd(reg_rd),
        .reg_rdata(reg_rdata),
        .reg_rvalid(reg_rvalid),
        .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int         pop_cyc[$];
    logic [7:0] regmem [0:127];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_wr, n_rd, n_ferr;
    int         last_wr_cyc, last_rd_cyc, last_ferr_cyc, last_push_cyc;
    logic [6:0] last_wr_addr, last_rd_addr;
    logic [7:0] last_wr_data;
    bit         rsp_en = 1'b0;
    int         rsp_delay = 1;
    int         rsp_cnt = 0;
    logic [7:0] rsp_data = 8'h00;
    logic       s_rd_uart, s_wr_uart;

    task automatic upd_rx();
        rx_empty = (rxq.size() == 0);
        rd_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        upd_rx();
    endtask

    task automatic clear_log();
        txq.delete();
        pop_cyc.delete();
        n_wr = 0; n_rd = 0; n_ferr = 0;
        last_wr_cyc = 0; last_rd_cyc = 0; last_ferr_cyc = 0; last_push_cyc = 0;
        last_wr_addr = 7'h00; last_rd_addr = 7'h00; last_wr_data = 8'h00;
    endtask

    // One clock cycle: sample mid-cycle, then update models just after the edge
    task automatic step();
        @(negedge clk);
        s_rd_uart = rd_uart;
        s_wr_uart = wr_uart;
        if (rd_uart) pop_cyc.push_back(cyc);
        if (wr_uart) begin txq.push_back(wr_data); last_push_cyc = cyc; end
        if (reg_wr) begin
            n_wr++; last_wr_cyc = cyc; last_wr_addr = reg_addr; last_wr_data = reg_wdata;
        end
        if (reg_rd) begin
            n_rd++; last_rd_cyc = cyc; last_rd_addr = reg_addr;
            if (rsp_en) begin rsp_cnt = rsp_delay; rsp_data = regmem[reg_addr]; end
        end
        if (frame_err) begin n_ferr++; last_ferr_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rd_uart && rxq.size() > 0) rxq.delete(0);
        upd_rx();
        reg_rvalid = 1'b0;
        reg_rdata  = 8'h00;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin reg_rvalid = 1'b1; reg_rdata = rsp_data; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        upd_rx();
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if ({rd_uart, wr_uart, reg_wr, reg_rd, frame_err} !== 5'b0) begin
            errors++; $display("FAIL rst_strobes got %b want 00000", {rd_uart, wr_uart, reg_wr, reg_rd, frame_err});
        end
        checks++; if ({reg_addr, reg_wdata, wr_data} !== 23'h0) begin
            errors++; $display("FAIL rst_data got %h/%h/%h want 0", reg_addr, reg_wdata, wr_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write();
        clear_log();
        push_rx(8'h85); push_rx(8'h3C);
        repeat (8) step();
        checks++; if (n_wr != 1) begin errors++; $display("FAIL wr_count got %0d want 1", n_wr); end
        checks++; if (last_wr_addr !== 7'h05) begin errors++; $display("FAIL wr_addr got %h want 05", last_wr_addr); end
        checks++; if (last_wr_data !== 8'h3C) begin errors++; $display("FAIL wr_wdata got %h want 3c", last_wr_data); end
        checks++; if (txq.size() != 1 || txq[0] !== 8'h06) begin
            errors++; $display("FAIL wr_resp got n=%0d b=%h want n=1 b=06", txq.size(), txq[0]);
        end
        checks++; if (pop_cyc.size() != 2 || pop_cyc[1] - pop_cyc[0] != 1) begin
            errors++; $display("FAIL wr_pop_gap got n=%0d want 2 pops 1 cycle apart", pop_cyc.size());
        end
        checks++; if (last_wr_cyc - pop_cyc[1] != 1) begin
            errors++; $display("FAIL wr_strobe_lat got %0d want 1", last_wr_cyc - pop_cyc[1]);
        end
        checks++; if (last_push_cyc - last_wr_cyc != 1) begin
            errors++; $display("FAIL wr_push_lat got %0d want 1", last_push_cyc - last_wr_cyc);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b want 0", busy); end
    endtask

    task automatic test_read();
        clear_log();
        rsp_en = 1'b1; rsp_delay = 3;
        push_rx(8'h12);
        repeat (10) step();
        checks++; if (n_rd != 1 || last_rd_addr !== 7'h12) begin
            errors++; $display("FAIL rd_strobe got n=%0d addr=%h want n=1 addr=12", n_rd, last_rd_addr);
        end
        checks++; if (txq.size() != 1 || txq[0] !== 8'hA7) begin
            errors++; $display("FAIL rd_resp got n=%0d b=%h want n=1 b=a7", txq.size(), txq[0]);
        end
        checks++; if (last_rd_cyc - pop_cyc[0] != 1) begin
            errors++; $display("FAIL rd_strobe_lat got %0d want 1", last_rd_cyc - pop_cyc[0]);
        end
        checks++; if (last_push_cyc - last_rd_cyc != 4) begin
            errors++; $display("FAIL rd_push_lat got %0d want 4", last_push_cyc - last_rd_cyc);
        end
        checks++; if (n_ferr != 0 || n_wr != 0) begin
            errors++; $display("FAIL rd_side_effects got ferr=%0d wr=%0d want 0 0", n_ferr, n_wr);
        end
    endtask

    task automatic test_wr_timeout();
        int p;
        clear_log();
        p = cyc;
        push_rx(8'h81);
        repeat (25) step();
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL wto_ferr_count got %0d want 1", n_ferr); end
        checks++; if (last_ferr_cyc - (p + 1) != TO) begin
            errors++; $display("FAIL wto_ferr_time got %0d want %0d", last_ferr_cyc - (p + 1), TO);
        end
        checks++; if (n_wr != 0 || txq.size() != 0) begin
            errors++; $display("FAIL wto_no_resp got wr=%0d tx=%0d want 0 0", n_wr, txq.size());
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wto_busy got %b want 0", busy); end
    endtask

    task automatic test_wr_late_data();
        int p;
        clear_log();
        p = cyc;
        push_rx(8'h83);
        step();
        while (cyc < p + TO) step();
        push_rx(8'h77);
        repeat (6) step();
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL late_ferr got %0d want 0", n_ferr); end
        checks++; if (n_wr != 1 || last_wr_addr !== 7'h03 || last_wr_data !== 8'h77) begin
            errors++; $display("FAIL late_write got n=%0d a=%h d=%h want 1 03 77", n_wr, last_wr_addr, last_wr_data);
        end
        checks++; if (txq.size() != 1 || txq[0] !== 8'h06) begin
            errors++; $display("FAIL late_resp got n=%0d b=%h want n=1 b=06", txq.size(), txq[0]);
        end
    endtask

    task automatic test_rd_timeout();
        clear_log();
        rsp_en = 1'b0;
        push_rx(8'h33);
        repeat (24) step();
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL rto_ferr_count got %0d want 1", n_ferr); end
        checks++; if (txq.size() != 1 || txq[0] !== 8'h15) begin
            errors++; $display("FAIL rto_resp got n=%0d b=%h want n=1 b=15", txq.size(), txq[0]);
        end
        checks++; if (last_push_cyc - last_rd_cyc != TO + 1 || last_ferr_cyc != last_push_cyc) begin
            errors++; $display("FAIL rto_timing got push=%0d ferr=%0d want %0d %0d",
                               last_push_cyc - last_rd_cyc, last_ferr_cyc - last_rd_cyc, TO + 1, TO + 1);
        end
    endtask

    task automatic test_rvalid_tie();
        clear_log();
        rsp_en = 1'b1; rsp_delay = TO;
        push_rx(8'h2A);
        repeat (24) step();
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL tie_ferr got %0d want 0", n_ferr); end
        checks++; if (txq.size() != 1 || txq[0] !== 8'h3E) begin
            errors++; $display("FAIL tie_resp got n=%0d b=%h want n=1 b=3e", txq.size(), txq[0]);
        end
        checks++; if (last_push_cyc - last_rd_cyc != TO + 1) begin
            errors++; $display("FAIL tie_lat got %0d want %0d", last_push_cyc - last_rd_cyc, TO + 1);
        end
    endtask

    task automatic test_stray_rvalid();
        clear_log();
        reg_rvalid = 1'b1; reg_rdata = 8'hEE;
        repeat (4) step();
        checks++; if (txq.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_rvalid got tx=%0d busy=%b want 0 0", txq.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int viol;
        clear_log();
        rsp_en = 1'b1; rsp_delay = 1;
        tx_full = 1'b1;
        push_rx(8'h21); push_rx(8'h44); push_rx(8'h82); push_rx(8'h99);
        repeat (3) step();
        viol = 0;
        repeat (10) begin
            step();
            if (s_rd_uart || s_wr_uart) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bp_handshake got %0d active cycles want 0", viol); end
        checks++; if (txq.size() != 0 || rxq.size() != 3) begin
            errors++; $display("FAIL bp_hold got tx=%0d rx=%0d want 0 3", txq.size(), rxq.size());
        end
        tx_full = 1'b0;
        repeat (20) step();
        checks++; if (txq.size() != 3) begin errors++; $display("FAIL bp_push_count got %0d want 3", txq.size()); end
        checks++; if (txq[0] !== 8'hC3 || txq[1] !== 8'h5E || txq[2] !== 8'h06) begin
            errors++; $display("FAIL bp_order got %h %h %h want c3 5e 06", txq[0], txq[1], txq[2]);
        end
        checks++; if (n_rd != 2 || n_wr != 1 || last_wr_addr !== 7'h02 || last_wr_data !== 8'h99) begin
            errors++; $display("FAIL bp_frames got rd=%0d wr=%0d a=%h d=%h want 2 1 02 99",
                               n_rd, n_wr, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        push_rx(8'h90);
        repeat (2) step();
        checks++; if (busy !== 1'b1 || reg_addr !== 7'h10) begin
            errors++; $display("FAIL mid_pre got busy=%b a=%h want 1 10", busy, reg_addr);
        end
        reset = 1'b0;
        #1;
        checks++; if ({busy, rd_uart, wr_uart, reg_wr, reg_rd, frame_err} !== 6'b0) begin
            errors++; $display("FAIL mid_rst_ctrl got %b want 000000", {busy, rd_uart, wr_uart, reg_wr, reg_rd, frame_err});
        end
        checks++; if ({reg_addr, reg_wdata, wr_data} !== 23'h0) begin
            errors++; $display("FAIL mid_rst_data got %h/%h/%h want 0", reg_addr, reg_wdata, wr_data);
        end
        repeat (2) step();
        reset = 1'b1;
        step();
        clear_log();
        rsp_en = 1'b1; rsp_delay = 1;
        push_rx(8'h10);
        repeat (8) step();
        checks++; if (n_rd != 1 || last_rd_addr !== 7'h10 || n_wr != 0 || n_ferr != 0) begin
            errors++; $display("FAIL mid_after got rd=%0d a=%h wr=%0d ferr=%0d want 1 10 0 0",
                               n_rd, last_rd_addr, n_wr, n_ferr);
        end
        checks++; if (txq.size() != 1 || txq[0] !== 8'h5A) begin
            errors++; $display("FAIL mid_resp got n=%0d b=%h want n=1 b=5a", txq.size(), txq[0]);
        end
    endtask

    initial begin
        regmem[7'h12] = 8'hA7;
        regmem[7'h21] = 8'hC3;
        regmem[7'h44] = 8'h5E;
        regmem[7'h2A] = 8'h3E;
        regmem[7'h10] = 8'h5A;
        clear_log();
        test_reset();
        test_write();
        test_read();
        test_wr_timeout();
        test_wr_late_data();
        test_rd_timeout();
        test_rvalid_tie();
        test_stray_rvalid();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Command responder on the host side of the UART byte interface. It consumes the UART receive-FIFO handshake (rd_data, rx_empty, rd_uart) and produces the transmit-FIFO handshake (wr_data, wr_uart, tx_full).
- It decodes 1- or 2-byte command frames into single-cycle register-bus read and write strobes, then returns exactly one response byte per completed frame.
- It gives an external UART host peek/poke access to a register file.

Parameters:
- ADDR_W, 7: register address width; must be <= 7, because the address is the low 7 bits of the command byte.
- DATA_W, 8: register data width; fixed at 8 to match the UART byte.
- TIMEOUT_CYC, 65535: clk cycles allowed for the write-data byte to arrive, and for reg_rvalid to arrive after reg_rd.
- ACK_BYTE, 8'h06: response to a completed write.
- NAK_BYTE, 8'h15: response to a read that timed out.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- rd_data, input, 8: head of the RX FIFO; valid whenever rx_empty=0 (first-word fall-through).
- rx_empty, input, 1: RX FIFO empty.
- rd_uart, output, 1: RX FIFO pop strobe.
- wr_data, output, 8: response byte to the TX FIFO.
- wr_uart, output, 1: TX FIFO push strobe.
- tx_full, input, 1: TX FIFO full.
- reg_addr, output, ADDR_W: register address.
- reg_wdata, output, 8: register write data.
- reg_wr, output, 1: register write strobe.
- reg_rd, output, 1: register read strobe.
- reg_rdata, input, 8: read data; sampled when reg_rvalid=1.
- reg_rvalid, input, 1: read data valid.
- busy, output, 1: high in every state except IDLE.
- frame_err, output, 1: one-cycle pulse on a write-data timeout or a read timeout.

Behaviour:
- Frame format:
  - Command byte: bit7=1 means write, bit7=0 means read; bits[ADDR_W-1:0] are the address; unused bits are ignored.
  - A write frame is the command byte followed by one data byte. A read frame is the command byte only.
- States and transitions:
  - IDLE: rd_uart = ~rx_empty, combinational. On a pop, rd_data is latched at the same edge, reg_addr is loaded, and the command's bit7 is latched. Next state is GET_DATA if bit7=1, otherwise REG_READ.
  - GET_DATA:
    - rd_uart = ~rx_empty. On a pop, reg_wdata <= rd_data and the next state is REG_WRITE.
    - The timeout counter is cleared on entry and increments every cycle while rx_empty=1.
    - When the counter reaches TIMEOUT_CYC-1 with no byte: frame_err pulses, no response is sent, and the next state is IDLE.
  - REG_WRITE: reg_wr=1 for exactly this one cycle; resp <= ACK_BYTE; next state SEND.
  - REG_READ: reg_rd=1 for exactly this one cycle; counter cleared; next state WAIT_RD.
  - WAIT_RD:
    - If reg_rvalid=1: resp <= reg_rdata and the next state is SEND. reg_rvalid is honoured in the cycle immediately after reg_rd, so minimum read latency is 1.
    - If the counter reaches TIMEOUT_CYC-1 first: resp <= NAK_BYTE, frame_err pulses, next state SEND.
  - SEND: wr_data = resp. wr_uart = ~tx_full, combinational. The state holds while tx_full=1; after the push, next state is IDLE.
- Strobe and output rules:
  - reg_wr, reg_rd and frame_err are registered state decodes, never more than one cycle wide.
  - rd_uart is asserted only in IDLE and GET_DATA.
  - wr_uart is asserted only in SEND.
  - reg_addr and reg_wdata hold their values until the next frame loads them.
- Latency, write frame with bytes back-to-back and tx_full=0: the data byte is popped the cycle after the command, reg_wr follows 1 cycle later, and wr_uart follows 1 cycle after that.
- Latency, read frame: reg_rd is asserted 1 cycle after the command pop, and wr_uart is asserted 1 cycle after reg_rvalid.
- Counter: width $clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- Boundary conditions:
  - No new frame is accepted until the response push completes. RX bytes wait in the RX FIFO, since there is no pop outside IDLE and GET_DATA.
  - A reg_rvalid arriving outside WAIT_RD is ignored.
  - reg_rvalid and timeout in the same cycle: reg_rvalid wins and frame_err is not pulsed.
  - A data byte arriving in the same cycle the timeout expires is accepted; the timeout only fires if rx_empty=1 in that cycle.
- Reset (reset=0, any time, including mid-frame): state IDLE; rd_uart, wr_uart, reg_wr, reg_rd, busy and frame_err are 0; reg_addr, reg_wdata, wr_data and resp are 0; counter is 0. A partial frame is discarded.

Test Plan:
- Write frame: push 8'h85 then 8'h3C into the RX model -> one reg_wr pulse with reg_addr=7'h05 and reg_wdata=8'h3C, then a single wr_uart with wr_data=8'h06.
- Read frame: push 8'h12; responder returns reg_rvalid 3 cycles after reg_rd with reg_rdata=8'hA7 -> one reg_rd pulse at addr 7'h12, then wr_data=8'hA7 pushed once.
- Write-data timeout (TIMEOUT_CYC=16): push 8'h81 only -> frame_err pulses 16 cycles after entering GET_DATA, no reg_wr, no wr_uart, and busy=0 afterwards.
- Read timeout: reg_rvalid never asserted -> frame_err pulses once and wr_data=8'h15 is pushed.
- Back-pressure: hold tx_full=1 for 10 cycles during a read response with 2 more commands queued -> wr_uart=0 and rd_uart=0 throughout; after release, exactly one push occurs, then the queued frames are processed in order.
- Reset mid-frame: assert reset=0 in GET_DATA after 8'h90 -> all outputs are 0 immediately; after release, a fresh 8'h10 read frame completes normally.
